// File: rtl/ex_alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/shift/compare ops plus
// iterative shift-add multiply and restoring divide behind valid/ready handshakes.
`timescale 1ns/1ps
module ex_alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             ovf,
    output logic             dz
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_NOR   = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_ROR   = 5'd9;
    localparam logic [4:0] OP_SEQ   = 5'd10;
    localparam logic [4:0] OP_SLT   = 5'd11;
    localparam logic [4:0] OP_SLTU  = 5'd12;
    localparam logic [4:0] OP_MULT  = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_ovf;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_mq;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_neg;
    logic                 r_rem_neg;
    logic                 r_div_zero;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [SHAMT_W-1:0]   w_rol_amt;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_sc_lo;
    logic                 w_sc_ovf;
    logic                 w_s1_neg;
    logic                 w_s2_neg;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [WIDTH:0]       w_madd;
    logic [WIDTH-1:0]     w_mul_acc;
    logic [WIDTH-1:0]     w_mul_mq;
    logic [WIDTH:0]       w_dsub;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_div_acc;
    logic [WIDTH-1:0]     w_div_mq;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept    = (r_state == S_IDLE) && in_valid && !flush;
    assign w_last      = (r_cnt == SHAMT_W'(WIDTH - 1));
    assign w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

    // Next-state decode; flush overrides every handshake
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!in_valid) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_div) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Rotate-right is built from a right shift and a left shift by the negated amount
    assign w_shamt   = src1[SHAMT_W-1:0];
    assign w_rol_amt = -w_shamt;
    assign w_sum     = src1 + src2;
    assign w_diff    = src1 - src2;

    // Single-cycle result and overflow
    always_comb begin
        w_sc_lo  = {WIDTH{1'b0}};
        w_sc_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                w_sc_lo  = w_sum;
                w_sc_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_lo  = w_diff;
                w_sc_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_diff[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_AND:  w_sc_lo = src1 & src2;
            OP_OR:   w_sc_lo = src1 | src2;
            OP_NOR:  w_sc_lo = ~(src1 | src2);
            OP_XOR:  w_sc_lo = src1 ^ src2;
            OP_SLL:  w_sc_lo = src2 << w_shamt;
            OP_SRL:  w_sc_lo = src2 >> w_shamt;
            OP_SRA:  w_sc_lo = WIDTH'($signed(src2) >>> w_shamt);
            OP_ROR:  w_sc_lo = (src2 >> w_shamt) | (src2 << w_rol_amt);
            OP_SEQ:  w_sc_lo = {{(WIDTH-1){1'b0}}, (src1 == src2)};
            OP_SLT:  w_sc_lo = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU: w_sc_lo = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            default: begin
                w_sc_lo  = {WIDTH{1'b0}};
                w_sc_ovf = 1'b0;
            end
        endcase
    end

    // Signed mul/div run on magnitudes; signs are reapplied on the final iteration
    assign w_s1_neg = w_is_signed && src1[WIDTH-1];
    assign w_s2_neg = w_is_signed && src2[WIDTH-1];
    assign w_mag1   = w_s1_neg ? -src1 : src1;
    assign w_mag2   = w_s2_neg ? -src2 : src2;

    assign w_madd    = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = w_madd[WIDTH:1];
    assign w_mul_mq  = {w_madd[0], r_mq[WIDTH-1:1]};

    assign w_dsub    = {r_acc, r_mq[WIDTH-1]} - {1'b0, r_a};
    assign w_qbit    = ~w_dsub[WIDTH];
    assign w_div_acc = w_qbit ? w_dsub[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
    assign w_div_mq  = {r_mq[WIDTH-2:0], w_qbit};

    assign w_prod     = {w_mul_acc, w_mul_mq};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_div_zero ? {WIDTH{1'b1}} : (r_neg ? -w_div_mq : w_div_mq);
    assign w_rem_fix  = r_rem_neg ? -w_div_acc : w_div_acc;

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo       <= {WIDTH{1'b0}};
            r_hi       <= {WIDTH{1'b0}};
            r_ovf      <= 1'b0;
            r_dz       <= 1'b0;
            r_a        <= {WIDTH{1'b0}};
            r_mq       <= {WIDTH{1'b0}};
            r_acc      <= {WIDTH{1'b0}};
            r_cnt      <= {SHAMT_W{1'b0}};
            r_neg      <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_lo       <= w_sc_lo;
            r_hi       <= {WIDTH{1'b0}};
            r_ovf      <= w_sc_ovf;
            r_dz       <= 1'b0;
            r_a        <= w_mag2;
            r_mq       <= w_mag1;
            r_acc      <= {WIDTH{1'b0}};
            r_cnt      <= {SHAMT_W{1'b0}};
            r_neg      <= w_s1_neg ^ w_s2_neg;
            r_rem_neg  <= w_s1_neg;
            r_div_zero <= w_is_div && (src2 == {WIDTH{1'b0}});
        end else if ((r_state == S_MUL) && !flush) begin
            r_acc <= w_mul_acc;
            r_mq  <= w_mul_mq;
            r_cnt <= r_cnt + {{(SHAMT_W-1){1'b0}}, 1'b1};
            if (w_last) begin
                r_lo <= w_prod_fix[WIDTH-1:0];
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            end
        end else if ((r_state == S_DIV) && !flush) begin
            r_acc <= w_div_acc;
            r_mq  <= w_div_mq;
            r_cnt <= r_cnt + {{(SHAMT_W-1){1'b0}}, 1'b1};
            if (w_last) begin
                r_lo <= w_quo_fix;
                r_hi <= w_rem_fix;
                r_dz <= r_div_zero;
            end
        end
    end
endmodule

// File: doc/ex_alu_mc.md
# ex_alu_mc

Parametrised, multi-cycle execute-stage ALU: the successor to our single-cycle combinational ALU. It adds configurable datapath width, a registered valid/ready handshake on both sides, iterative signed/unsigned multiply and divide producing HI/LO, and signed-overflow and divide-by-zero flags. It sits between issue and writeback in the EX stage. It accepts one operation at a time and holds its result until the consumer takes it.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be a power of two, at least 8
- SHAMT_W, $clog2(WIDTH), number of shift-amount bits taken from src1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort any in-flight op; drop any held result
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept (high only in IDLE)
- op  in  5  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 ROR, 10 SEQ, 11 SLT, 12 SLTU, 13 MULT, 14 MULTU, 15 DIV, 16 DIVU; 17–31 reserved
- src1  in  WIDTH  operand 1; shift amount for shifts
- src2  in  WIDTH  operand 2; shifted value for shifts
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result_lo  out  WIDTH  main result; product low half; quotient
- result_hi  out  WIDTH  product high half; remainder; 0 for single-cycle ops
- ovf  out  1  signed overflow (ADD/SUB only)
- dz  out  1  divide by zero (DIV/DIVU only)

## Operation
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge. Operands and op are captured into internal registers.
  - Output transfer: out_valid & out_ready at a rising edge.
- States:
  - IDLE: in_ready=1.
  - MUL: iterative shift-add multiply.
  - DIV: iterative restoring divide.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→DONE on accepting ops 0–12 or a reserved op.
  - IDLE→MUL on accepting 13/14.
  - IDLE→DIV on accepting 15/16.
  - MUL/DIV→DONE after exactly WIDTH iteration cycles.
  - DONE→IDLE on output transfer.
  - Any state→IDLE on flush.
- Single-cycle op results:
  - ADD/SUB: modulo 2^WIDTH. ovf=1 when the operand signs imply signed overflow.
  - Shift amount is src1[SHAMT_W-1:0].
  - SRA is arithmetic.
  - ROR is a right rotate; amount 0 returns src2 unchanged.
  - SEQ/SLT/SLTU produce 1 or 0. SLT is signed, SLTU unsigned.
  - Reserved ops: result_lo=0, ovf=0, dz=0.
- MULT/MULTU: full 2·WIDTH-bit product {result_hi,result_lo}. MULT is signed; it takes operand magnitudes and negates the product at the end when the signs differ.
- DIV/DIVU:
  - Quotient goes to result_lo, remainder to result_hi.
  - Signed quotient truncates toward zero; remainder takes the sign of src1.
  - Divisor 0: dz=1, result_lo = all ones, result_hi = src1.
  - DIV of most-negative value by −1: result_lo = most-negative value, result_hi = 0, dz=0.
- ovf and dz are 0 for every op other than those listed above.
- All outputs are registered and stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset: on a rising edge with rst=1, state=IDLE and out_valid=0.
  - result_lo, result_hi, ovf and dz all reset to 0.
  - in_ready=1 from the first cycle after reset release.
- rst has priority over flush. flush has priority over the handshake: an in_valid in the same cycle as flush is not accepted.
- Latency from input transfer to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles (WIDTH iterations, then DONE).
- Throughput: no overlap. in_ready is 0 from the cycle after acceptance until the cycle after output transfer. Maximum throughput is one op per 2 cycles with out_ready held high.
- Back-pressure: DONE holds indefinitely while out_ready=0.
- Flush or reset mid-MUL/DIV:
  - Partial state is discarded and out_valid stays 0.
  - The next op is accepted in the cycle after flush.
- Multiply and divide use one WIDTH-bit adder/subtractor iteration per cycle. No combinational path exists from inputs to outputs. in_ready depends on state only.

## Test plan
- Reset with WIDTH=32 → out_valid=0, all outputs 0, in_ready=1. Then ADD 0x7FFFFFFF+1 → one cycle later result_lo=0x80000000, ovf=1, result_hi=0.
- Shifts:
  - ROR src2=0x80000001, src1=1 → result_lo=0xC0000000.
  - ROR src1=0 → result_lo=src2.
  - SRA src2=0x80000000, src1=31 → result_lo=0xFFFFFFFF.
- MULT −3 × 5 → out_valid exactly 33 cycles after acceptance, {hi,lo}=0xFFFFFFFF_FFFFFFF1.
- MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=0x00000001.
- Divide:
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 9/0 → dz=1, lo=0xFFFFFFFF, hi=9.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Control:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0.
  - Flush at cycle 5 of a DIV → out_valid never rises; a new ADD is accepted in the following cycle.
  - Repeat the DIV with rst instead of flush → same behaviour.
